// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle adder/subtracter for the ALU datapath.
// Operands are processed CHUNK bits per clock, least significant slice first,
// with the carry chain held in a register between slices. This keeps the
// combinational path to a CHUNK-bit adder at the cost of WIDTH/CHUNK cycles.
// Subtraction is done as A + ~B + 1: B is inverted on accept and the carry
// register is seeded with 1. That makes the latched carry the only place the
// operation type has to live, so no separate 'sub' register is kept.
module addsub_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             zero_o,
  output logic             negative_o
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             nonzero_q, nonzero_d;
  logic             cout_q, cout_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             negative_q, negative_d;

  logic             accept;
  logic             running;
  logic             lastSlice;
  logic [31:0]      sliceBase;
  logic [CHUNK-1:0] sliceA;
  logic [CHUNK-1:0] sliceB;
  logic [CHUNK-1:0] sliceSum;
  logic             sliceCarry;

  // Handshake qualifiers and slice position derived from the current state
  always_comb begin
    accept    = (state_q == IDLE) & in_valid_i;
    running   = (state_q == RUN);
    lastSlice = (count_q == LAST_SLICE);
    sliceBase = 32'(count_q) * CHUNK;
  end

  // One CHUNK-bit ripple step: current slice of A and B_eff plus the carry in
  always_comb begin
    sliceA = opA_q[sliceBase +: CHUNK];
    sliceB = opB_q[sliceBase +: CHUNK];
    {sliceCarry, sliceSum} = {1'b0, sliceA} + {1'b0, sliceB} + {{CHUNK{1'b0}}, carry_q};
  end

  // Control FSM: IDLE accepts, RUN walks the slices, DONE waits for the consumer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (lastSlice) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand capture on accept; operands are frozen for the rest of the operation
  always_comb begin
    opA_d = opA_q;
    opB_d = opB_q;
    if (accept) begin
      opA_d = a_i;
      opB_d = sub_i ? ~b_i : b_i;
    end
  end

  // Carry chain and slice counter: seeded on accept, advanced once per RUN cycle
  always_comb begin
    carry_d = carry_q;
    count_d = count_q;
    if (accept) begin
      carry_d = sub_i;
      count_d = '0;
    end else if (running) begin
      carry_d = sliceCarry;
      if (!lastSlice) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Result assembly: each RUN cycle fills one slice and folds it into the nonzero tracker
  always_comb begin
    result_d  = result_q;
    nonzero_d = nonzero_q;
    if (accept) begin
      result_d  = '0;
      nonzero_d = 1'b0;
    end else if (running) begin
      result_d[sliceBase +: CHUNK] = sliceSum;
      nonzero_d = nonzero_q | (|sliceSum);
    end
  end

  // Flags are only updated on the final slice so they stay put through DONE and the next RUN
  always_comb begin
    cout_d     = cout_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    negative_d = negative_q;
    if (running && lastSlice) begin
      cout_d     = sliceCarry;
      overflow_d = (opA_q[WIDTH-1] == opB_q[WIDTH-1]) & (sliceSum[CHUNK-1] != opA_q[WIDTH-1]);
      negative_d = sliceSum[CHUNK-1];
      zero_d     = ~(nonzero_q | (|sliceSum));
    end
  end

  // Control state registers; reset overrides accept, slice processing and consumption
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

  // Operand registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      opA_q <= '0;
      opB_q <= '0;
    end else begin
      opA_q <= opA_d;
      opB_q <= opB_d;
    end
  end

  // Result and flag registers; cleared by reset so an aborted operation leaves nothing behind
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_q   <= '0;
      nonzero_q  <= 1'b0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      result_q   <= result_d;
      nonzero_q  <= nonzero_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
    end
  end

  // Outputs come straight from registers, so they are glitch-free and stable in DONE
  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
    result_o    = result_q;
    cout_o      = cout_q;
    overflow_o  = overflow_q;
    zero_o      = zero_q;
    negative_o  = negative_q;
  end

endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: drives three addsub_seq instances (CHUNK = 4, 64, 1) with
// identical operands and compares each against an arithmetic reference model.
module tb_addsub_seq;

  localparam int W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         inValid;
  logic         outReady;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;

  logic [2:0]   inReady;
  logic [2:0]   outValid;
  logic [2:0]   coutV;
  logic [2:0]   ovfV;
  logic [2:0]   zeroV;
  logic [2:0]   negV;
  logic [W-1:0] res [3];

  logic [W-1:0] capRes [3];
  logic         capC [3];
  logic         capV [3];
  logic         capZ [3];
  logic         capN [3];
  int           lat [3];

  int errors = 0;
  int checks = 0;

  addsub_seq #(.WIDTH(W), .CHUNK(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(inValid), .in_ready_o(inReady[0]),
    .a_i(a), .b_i(b), .sub_i(sub), .out_valid_o(outValid[0]), .out_ready_i(outReady),
    .result_o(res[0]), .cout_o(coutV[0]), .overflow_o(ovfV[0]), .zero_o(zeroV[0]),
    .negative_o(negV[0])
  );

  addsub_seq #(.WIDTH(W), .CHUNK(64)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(inValid), .in_ready_o(inReady[1]),
    .a_i(a), .b_i(b), .sub_i(sub), .out_valid_o(outValid[1]), .out_ready_i(outReady),
    .result_o(res[1]), .cout_o(coutV[1]), .overflow_o(ovfV[1]), .zero_o(zeroV[1]),
    .negative_o(negV[1])
  );

  addsub_seq #(.WIDTH(W), .CHUNK(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(inValid), .in_ready_o(inReady[2]),
    .a_i(a), .b_i(b), .sub_i(sub), .out_valid_o(outValid[2]), .out_ready_i(outReady),
    .result_o(res[2]), .cout_o(coutV[2]), .overflow_o(ovfV[2]), .zero_o(zeroV[2]),
    .negative_o(negV[2])
  );

  // Expected latency of each instance: WIDTH / CHUNK
  function automatic int expLat(input int k);
    case (k)
      0:       return 16;
      1:       return 1;
      default: return 64;
    endcase
  endfunction

  // Reference: true mathematical result in wider arithmetic, then derive the flags from it
  function automatic void refModel(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                   output logic [W-1:0] r, output logic c, output logic v,
                                   output logic z, output logic n);
    logic [W:0]          tot;
    logic signed [W+1:0] sx;
    logic signed [W+1:0] sy;
    logic signed [W+1:0] sr;
    sx = $signed({{2{x[W-1]}}, x});
    sy = $signed({{2{y[W-1]}}, y});
    if (s) begin
      r  = x - y;
      c  = (x >= y);
      sr = sx - sy;
    end else begin
      tot = {1'b0, x} + {1'b0, y};
      r   = tot[W-1:0];
      c   = tot[W];
      sr  = sx + sy;
    end
    v = (sr != $signed({{2{r[W-1]}}, r}));
    z = (r == '0);
    n = r[W-1];
  endfunction

  // Present one operand set at a negedge, let it be accepted, scramble inputs during RUN,
  // then wait (bounded) until every instance raises out_valid. Leaves them all in DONE.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [2:0] seen;
    seen = '0;
    for (int k = 0; k < 3; k++) lat[k] = -1;
    a = x;
    b = y;
    sub = s;
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    sub = 1'($urandom_range(0, 1));
    for (int n = 1; n <= 100 && seen != 3'b111; n++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!seen[k] && outValid[k]) begin
          seen[k]   = 1'b1;
          lat[k]    = n;
          capRes[k] = res[k];
          capC[k]   = coutV[k];
          capV[k]   = ovfV[k];
          capZ[k]   = zeroV[k];
          capN[k]   = negV[k];
        end
      end
    end
  endtask

  // Consume the result on every instance with a single out_ready pulse
  task automatic releaseOutput;
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    inValid = 1'b0;
    outReady = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (inReady !== 3'b111 || outValid !== 3'b000) begin
      errors++;
      $display("FAIL reset handshake: in_ready=%b out_valid=%b expected 111/000", inReady, outValid);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (res[k] !== '0 || {coutV[k], ovfV[k], zeroV[k], negV[k]} !== 4'b0000) begin
        errors++;
        $display("FAIL reset outputs dut%0d: result=%h flags=%b expected 0/0000", k, res[k],
                 {coutV[k], ovfV[k], zeroV[k], negV[k]});
      end
    end
    inValid = 1'b1;
    a = 64'd7;
    b = 64'd9;
    @(negedge clk);
    checks++;
    if (inReady !== 3'b111) begin
      errors++;
      $display("FAIL reset_vs_accept: in_ready=%b expected 111", inReady);
    end
    rst = 1'b0;
    inValid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arith;
    logic [W-1:0] xs [$];
    logic [W-1:0] ys [$];
    logic         ss [$];
    logic [W-1:0] x, y, er;
    logic         ec, ev, ez, en;
    xs.push_back(64'd1);                   ys.push_back(64'd1);                   ss.push_back(1'b0);
    xs.push_back(64'd5);                   ys.push_back(64'd5);                   ss.push_back(1'b1);
    xs.push_back(64'h7FFF_FFFF_FFFF_FFFF); ys.push_back(64'd1);                   ss.push_back(1'b0);
    xs.push_back(64'h8000_0000_0000_0000); ys.push_back(64'd1);                   ss.push_back(1'b1);
    xs.push_back(64'hFFFF_FFFF_FFFF_FFFF); ys.push_back(64'd1);                   ss.push_back(1'b0);
    xs.push_back(64'd0);                   ys.push_back(64'd1);                   ss.push_back(1'b1);
    for (int i = 0; i < 16; i++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: ;
        1: y = x;
        2: begin x = {1'b0, {(W-1){1'b1}}} - 64'($urandom_range(0, 3)); y = 64'($urandom_range(0, 5)); end
        default: begin x = 64'($urandom_range(0, 20)); y = 64'($urandom_range(0, 20)); end
      endcase
      xs.push_back(x);
      ys.push_back(y);
      ss.push_back(1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < xs.size(); i++) begin
      applyStimulus(xs[i], ys[i], ss[i]);
      refModel(xs[i], ys[i], ss[i], er, ec, ev, ez, en);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (lat[k] != expLat(k)) begin
          errors++;
          $display("FAIL arith op%0d dut%0d latency: got %0d expected %0d", i, k, lat[k], expLat(k));
        end
        checks++;
        if (capRes[k] !== er) begin
          errors++;
          $display("FAIL arith op%0d dut%0d result: got %h expected %h", i, k, capRes[k], er);
        end
        checks++;
        if ({capC[k], capV[k], capZ[k], capN[k]} !== {ec, ev, ez, en}) begin
          errors++;
          $display("FAIL arith op%0d dut%0d flags(c,v,z,n): got %b expected %b", i, k,
                   {capC[k], capV[k], capZ[k], capN[k]}, {ec, ev, ez, en});
        end
      end
      releaseOutput();
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] x1, y1, x2, y2, er;
    logic         ec, ev, ez, en;
    x1 = {$urandom, $urandom};
    y1 = {$urandom, $urandom};
    x2 = {$urandom, $urandom};
    y2 = {$urandom, $urandom};
    applyStimulus(x1, y1, 1'b0);
    refModel(x1, y1, 1'b0, er, ec, ev, ez, en);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (capRes[k] !== er || capC[k] !== ec) begin
        errors++;
        $display("FAIL bp first dut%0d: got %h/%b expected %h/%b", k, capRes[k], capC[k], er, ec);
      end
    end
    a = x2;
    b = y2;
    sub = 1'b1;
    inValid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (outValid !== 3'b111 || inReady !== 3'b000) begin
        errors++;
        $display("FAIL bp hold cycle%0d: out_valid=%b in_ready=%b expected 111/000", c, outValid, inReady);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (res[k] !== capRes[k] || {coutV[k], ovfV[k], zeroV[k], negV[k]} !==
            {capC[k], capV[k], capZ[k], capN[k]}) begin
          errors++;
          $display("FAIL bp stable cycle%0d dut%0d: result=%h expected %h", c, k, res[k], capRes[k]);
        end
      end
    end
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    checks++;
    if (inReady !== 3'b111 || outValid !== 3'b000) begin
      errors++;
      $display("FAIL bp release: in_ready=%b out_valid=%b expected 111/000", inReady, outValid);
    end
    applyStimulus(x2, y2, 1'b1);
    refModel(x2, y2, 1'b1, er, ec, ev, ez, en);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (lat[k] != expLat(k) || capRes[k] !== er || capC[k] !== ec || capV[k] !== ev) begin
        errors++;
        $display("FAIL bp second dut%0d: lat=%0d result=%h c=%b v=%b expected lat=%0d %h c=%b v=%b",
                 k, lat[k], capRes[k], capC[k], capV[k], expLat(k), er, ec, ev);
      end
    end
    releaseOutput();
  endtask

  task automatic test_reset_midrun;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    sub = 1'b0;
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (inReady !== 3'b111 || outValid !== 3'b000) begin
      errors++;
      $display("FAIL midrun reset handshake: in_ready=%b out_valid=%b expected 111/000", inReady, outValid);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (res[k] !== '0 || {coutV[k], ovfV[k], zeroV[k], negV[k]} !== 4'b0000) begin
        errors++;
        $display("FAIL midrun reset outputs dut%0d: result=%h flags=%b expected 0/0000", k, res[k],
                 {coutV[k], ovfV[k], zeroV[k], negV[k]});
      end
    end
    applyStimulus(64'd3, 64'd10, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (lat[k] != expLat(k) || capRes[k] !== 64'hFFFF_FFFF_FFFF_FFF9 || capC[k] !== 1'b0 ||
          capN[k] !== 1'b1) begin
        errors++;
        $display("FAIL midrun 3-10 dut%0d: lat=%0d result=%h c=%b n=%b expected lat=%0d fff..f9 c=0 n=1",
                 k, lat[k], capRes[k], capC[k], capN[k], expLat(k));
      end
    end
    releaseOutput();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] addsub_seq bench starting");
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
